// File: rtl/spi_link_pkg.sv
// Definitions shared by both ends of the 3-wire register-write SPI link:
// frame geometry, controller state encoding and peripheral register map.
package spi_link_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// SCLK half-period timer: pulses tick on the last clk of every CLK_DIV-cycle
// phase while enabled; held at zero while disabled so each phase starts fresh.
module spi_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator: takes one register write per valid/ready handshake and
// shifts a 16-bit {write, addr, data} frame out MSB first under nCS.
module spi_reg_writer
    import spi_link_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              spi_sclk,
    output logic              spi_copi,
    output logic              spi_ncs
);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("spi_reg_writer: CLK_DIV must be >= 2");
        end
        if (CS_SETUP < 1) begin : g_bad_setup
            $error("spi_reg_writer: CS_SETUP must be >= 1");
        end
        if (CS_HOLD < 1) begin : g_bad_hold
            $error("spi_reg_writer: CS_HOLD must be >= 1");
        end
        if (CS_IDLE < 1) begin : g_bad_idle
            $error("spi_reg_writer: CS_IDLE must be >= 1");
        end
    endgenerate

    // One counter times the setup, hold and gap phases; they never overlap.
    localparam int CNT_MAX = max3(CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [3:0]       BIT_LAST   = 4'(FRAME_W - 1);

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [3:0]         bit_cnt;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               busy_q;
    logic               tick;
    logic               shifting;

    assign shifting = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);

    spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (shifting),
        .tick (tick)
    );

    // Ready must drop in the very cycle rst is asserted, not one cycle later.
    assign req_ready = ready_q & ~rst;
    assign busy      = busy_q | (req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done     <= 1'b0;
            spi_ncs  <= 1'b1;
            spi_sclk <= 1'b0;
            spi_copi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        shreg    <= {req_write, req_addr, req_data};
                        spi_copi <= req_write;
                        spi_ncs  <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHIFT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        spi_sclk <= 1'b1;
                        state    <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    // Next bit goes out on the falling edge, half a period
                    // before the responder samples it on the rising edge.
                    if (tick) begin
                        spi_sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                            spi_copi <= shreg[FRAME_W-2];
                            state    <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        spi_ncs  <= 1'b1;
                        spi_copi <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == IDLE_LAST) begin
                        cnt     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed + randomized bench for spi_reg_writer; each frame is checked cycle
// by cycle against timing derived from the frame-level arithmetic.
module tb_spi_reg_writer;
    import spi_link_pkg::*;

    localparam int CD = 4;
    localparam int SU = 2;
    localparam int HO = 2;
    localparam int ID = 2;
    localparam int S0 = 1 + SU;                // first SHIFT_LO cycle
    localparam int T  = 1 + SU + 32*CD + HO;   // nCS high / done cycle
    localparam int R  = T + ID;                // req_ready returns

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, busy, done, spi_sclk, spi_copi, spi_ncs;

    int tests = 0;
    int fails = 0;

    spi_reg_writer #(.CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HO), .CS_IDLE(ID)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .spi_sclk  (spi_sclk),
        .spi_copi  (spi_copi),
        .spi_ncs   (spi_ncs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and wait (bounded) for the cycle it will be accepted in.
    task automatic start(input logic w, input logic [6:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("accept_wait", 32'(ok), 32'd1);
    endtask

    // Entered at the negedge of the accept cycle (cycle 0); observes cycles 1..R.
    task automatic run_frame(input string tag, input logic [15:0] exp, input bit hold,
                             input logic w2, input logic [6:0] a2, input logic [7:0] d2,
                             input bit scramble);
        int bad = 0, first_bad = -1, rises = 0, dones = 0;
        logic [15:0] cap = '0;
        logic prev_sclk = 1'b0, prev_copi = 1'b0;
        logic e_ncs, e_sclk, e_done, e_ready, e_busy, cbad;
        for (int c = 1; c <= R; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req_valid = hold; req_write = w2; req_addr = a2; req_data = d2;
            end else if (scramble && c < R) begin
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 7'($urandom_range(0, 127));
                req_data  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            e_ncs   = (c < T) ? 1'b0 : 1'b1;
            e_sclk  = (c >= S0 && c < S0 + 32*CD) ? 1'(((c - S0) / CD) % 2) : 1'b0;
            e_done  = (c == T);
            e_ready = (c == R);
            e_busy  = (c < R) || hold;
            cbad = 1'b0;
            if (c < S0 && spi_copi !== exp[15]) cbad = 1'b1;
            if (c >= S0 + 32*CD && c < T && spi_copi !== exp[0]) cbad = 1'b1;
            if (c >= T && spi_copi !== 1'b0) cbad = 1'b1;
            if (spi_sclk && prev_sclk && spi_copi !== prev_copi) cbad = 1'b1;
            if (spi_ncs !== e_ncs || spi_sclk !== e_sclk || done !== e_done ||
                req_ready !== e_ready || busy !== e_busy || cbad) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (spi_sclk && !prev_sclk) begin
                cap = {cap[14:0], spi_copi};
                rises++;
            end
            if (done) dones++;
            prev_sclk = spi_sclk;
            prev_copi = spi_copi;
        end
        chk($sformatf("%s_wave(first_bad_cycle=%0d)", tag, first_bad), 32'(bad), 32'd0);
        chk({tag, "_rises"}, 32'(rises), 32'd16);
        chk({tag, "_frame"}, {16'd0, cap}, {16'd0, exp});
        chk({tag, "_dones"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int quiet_bad;
        logic       w;
        logic [6:0] a;
        logic [7:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ncs",   32'(spi_ncs),   32'd1);
        chk("rst_sclk",  32'(spi_sclk),  32'd0);
        chk("rst_copi",  32'(spi_copi),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Scenario 1: duty register write
        start(1'b1, REG_PWM_DUTY, 8'h80);
        run_frame("s1", 16'h8480, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0);

        // Scenario 2: back-to-back writes with req_valid held
        start(1'b1, REG_EN_OUT_7_0, 8'hFF);
        run_frame("s2a", 16'h80FF, 1'b1, 1'b1, REG_EN_PWM_7_0, 8'h0F, 1'b0);
        run_frame("s2b", 16'h820F, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0);

        // Scenario 3: write bit clear, all-ones payload
        start(1'b0, 7'h7F, 8'hFF);
        run_frame("s3", 16'h7FFF, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0);

        // Scenario 4: reset during SHIFT_HI of bit 7
        start(1'b1, 7'h33, 8'h5A);
        for (int c = 1; c < S0 + 2*CD*7 + CD; c++) begin
            @(posedge clk); #1;
            if (c == 1) req_valid = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("s4_pre_sclk", 32'(spi_sclk), 32'd1);
        chk("s4_pre_ncs",  32'(spi_ncs),  32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s4_ncs",   32'(spi_ncs),   32'd1);
        chk("s4_sclk",  32'(spi_sclk),  32'd0);
        chk("s4_copi",  32'(spi_copi),  32'd0);
        chk("s4_done",  32'(done),      32'd0);
        chk("s4_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0 || spi_ncs !== 1'b1 || spi_sclk !== 1'b0) quiet_bad++;
        end
        chk("s4_quiet", 32'(quiet_bad), 32'd0);
        start(1'b1, REG_EN_OUT_15_8, 8'hA5);
        run_frame("s4b", 16'h81A5, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0);

        // Scenario 5: request fields change while busy
        start(1'b1, REG_PWM_DUTY, 8'h3C);
        run_frame("s5", 16'h843C, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1);

        // Randomized frames: expected frame is just {write, addr, data}
        for (int i = 0; i < 4; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 7'($urandom_range(0, 127));
            d = 8'($urandom_range(0, 255));
            start(w, a, d);
            run_frame($sformatf("rnd%0d", i), {w, a, d}, 1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
